// File: rtl/bram_fifo_stream_ctrl_pkg.sv
// Shared defaults and count-width helper for the bram_fifo flow-control slice.
// The width helper is also used by bram_fifo so both sides agree on counter widths.
package syntzulu_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 25;
    localparam int DEF_DEPTH      = 256;

    // Occupancy range is 0..DEPTH+2: full RAM plus one in-flight read plus two skid words
    function automatic int fifo_cnt_width(input int depth);
        return $clog2(depth + 3);
    endfunction

endpackage

// File: rtl/bram_fifo_stream_ctrl_skid.sv
// Two-entry register FIFO holding words returned by the bram_fifo read port.
// The head only moves on a pop or when a word lands in an empty buffer.
module fifo_out_skid
    import syntzulu_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic [1:0]            count_o
);

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [1:0]            cnt_q, cnt_d;

    // Next-state decode for every push/pop combination at each fill level
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case (cnt_q)
            2'd0: begin
                if (push_i) begin
                    head_d = push_data_i;
                    cnt_d  = 2'd1;
                end else begin
                    cnt_d  = 2'd0;
                end
            end
            2'd1: begin
                if (push_i && pop_i) begin
                    head_d = push_data_i;
                end else if (push_i) begin
                    tail_d = push_data_i;
                    cnt_d  = 2'd2;
                end else if (pop_i) begin
                    cnt_d  = 2'd0;
                end else begin
                    cnt_d  = 2'd1;
                end
            end
            2'd2: begin
                if (pop_i) begin
                    head_d = tail_q;
                    if (push_i) begin
                        tail_d = push_data_i;
                        cnt_d  = 2'd2;
                    end else begin
                        cnt_d  = 2'd1;
                    end
                end else begin
                    cnt_d  = 2'd2;
                end
            end
            default: begin
                head_d = {DATA_WIDTH{1'b0}};
                tail_d = {DATA_WIDTH{1'b0}};
                cnt_d  = 2'd0;
            end
        endcase
    end

    // Entry and count registers; reset and flush both zero the stored data
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            head_q <= {DATA_WIDTH{1'b0}};
            tail_q <= {DATA_WIDTH{1'b0}};
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head_o  = head_q;
    assign count_o = cnt_q;

endmodule

// File: rtl/bram_fifo_stream_ctrl.sv
// Flow-control shell around a flagless bram_fifo with 1-cycle read latency:
// tracks RAM occupancy, prefetches into a 2-entry skid and presents valid/ready on both sides.
module bram_fifo_stream_ctrl
    import syntzulu_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int CNT_W      = fifo_cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] fifo_di,
    output logic                  fifo_wren,
    output logic                  fifo_rden,
    input  logic [DATA_WIDTH-1:0] fifo_do,
    output logic                  fifo_clear,
    output logic [CNT_W-1:0]      level,
    output logic                  empty
);

    logic [CNT_W-1:0] ram_cnt_q, ram_cnt_d;
    logic             inflight_q;
    logic [1:0]       skid_cnt_s;
    logic             m_valid_s;
    logic             pop_s;
    logic             ready_s;
    logic             wren_s;
    logic             rden_s;
    logic [2:0]       occ_s;

    assign m_valid_s = (skid_cnt_s != 2'd0);
    assign pop_s     = m_valid_s && m_ready;
    assign occ_s     = {1'b0, skid_cnt_s} + {2'b00, inflight_q};
    assign wren_s    = s_valid && ready_s;

    // Accept and read-issue decode; s_ready depends only on the registered RAM count
    always_comb begin
        ready_s = 1'b0;
        rden_s  = 1'b0;
        if (!rst && !clear) begin
            ready_s = (ram_cnt_q < CNT_W'(DEPTH));
            rden_s  = (ram_cnt_q != {CNT_W{1'b0}}) && (occ_s < (3'd2 + {2'b00, pop_s}));
        end else begin
            ready_s = 1'b0;
            rden_s  = 1'b0;
        end
    end

    assign ram_cnt_d = ram_cnt_q + CNT_W'(wren_s) - CNT_W'(rden_s);

    // RAM occupancy and read-in-flight tracking; clear drops any pending read data
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ram_cnt_q  <= {CNT_W{1'b0}};
            inflight_q <= 1'b0;
        end else begin
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= rden_s;
        end
    end

    fifo_out_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (clear),
        .push_i      (inflight_q),
        .push_data_i (fifo_do),
        .pop_i       (pop_s),
        .head_o      (m_data),
        .count_o     (skid_cnt_s)
    );

    assign s_ready    = ready_s;
    assign m_valid    = m_valid_s;
    assign fifo_di    = s_data;
    assign fifo_wren  = wren_s;
    assign fifo_rden  = rden_s;
    assign fifo_clear = clear;
    assign level      = ram_cnt_q + CNT_W'(inflight_q) + CNT_W'(skid_cnt_s);
    assign empty      = (level == {CNT_W{1'b0}});

endmodule
